// File: rtl/ifid_hazard_latch.sv
// ifid_hazard_latch: IF/ID pipeline register with fetch-side hazard handling (optional stall counter under IFID_STALL_CNT_EN)
module ifid_hazard_latch #(
    parameter logic [15:0] NOP_INSTR  = 16'h0800,
    parameter logic [15:0] HALT_INSTR = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic        imem_stall,
    input  logic [15:0] instr_in,
    input  logic [15:0] pc_inc_in,
    output logic [15:0] instr_out,
    output logic [15:0] pc_inc_out,
    output logic        valid_out,
    output logic        pc_en,
    output logic        bubble,
    output logic [15:0] stall_cnt
);
    typedef enum logic [1:0] {RUN, WAIT_MEM, KILL, HALTED} state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_instr;
    logic [15:0] r_pc_inc;
    logic        r_valid;
    logic        w_fetch;

    // fetch acceptance, PC enable, bubble request and next-state selection by input priority
    always_comb begin
        w_fetch     = !flush && !stall && !imem_stall && (r_state == RUN || r_state == WAIT_MEM);
        pc_en       = !rst && (flush || w_fetch);
        bubble      = !rst && !flush && stall;
        w_state_nxt = flush      ? (imem_stall ? KILL : RUN) :
                      stall      ? r_state :
                      imem_stall ? ((r_state == KILL || r_state == HALTED) ? r_state : WAIT_MEM) :
                      w_fetch    ? ((instr_in == HALT_INSTR) ? HALTED : RUN) :
                      (r_state == KILL) ? RUN : r_state;
    end

    // pipeline register: holds on stall, otherwise loads the fetched instruction or a NOP
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= RUN;
            r_instr  <= NOP_INSTR;
            r_pc_inc <= 16'h0000;
            r_valid  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (flush || !stall) begin
                r_instr <= w_fetch ? instr_in : NOP_INSTR;
                r_valid <= w_fetch;
            end
            if (w_fetch) r_pc_inc <= pc_inc_in;
        end
    end

    assign instr_out  = r_instr;
    assign pc_inc_out = r_pc_inc;
    assign valid_out  = r_valid;

`ifdef IFID_STALL_CNT_EN
    logic [15:0] r_stall_cnt;
    // saturating count of cycles lost to decode or memory stalls
    always_ff @(posedge clk) begin
        if (rst) r_stall_cnt <= 16'h0000;
        else if (!flush && (stall || imem_stall) && r_stall_cnt != 16'hFFFF) r_stall_cnt <= r_stall_cnt + 16'h0001;
    end
    assign stall_cnt = r_stall_cnt;
`else
    assign stall_cnt = 16'h0000;
`endif
endmodule

// File: tb/tb_ifid_hazard_latch.sv
// tb_ifid_hazard_latch: directed self-checking bench for ifid_hazard_latch
module tb_ifid_hazard_latch;
    logic        clk = 1'b0;
    logic        rst, stall, flush, imem_stall;
    logic [15:0] instr_in, pc_inc_in, instr_out, pc_inc_out, stall_cnt;
    logic        valid_out, pc_en, bubble;
    int          n_tests = 0;
    int          n_fail  = 0;

    ifid_hazard_latch dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .imem_stall(imem_stall),
        .instr_in(instr_in), .pc_inc_in(pc_inc_in), .instr_out(instr_out),
        .pc_inc_out(pc_inc_out), .valid_out(valid_out), .pc_en(pc_en),
        .bubble(bubble), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic s, input logic f, input logic m, input logic [15:0] i, input logic [15:0] p);
        stall = s; flush = f; imem_stall = m; instr_in = i; pc_inc_in = p;
        #1;
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 1, 0, 16'h0000, 16'h0000);
        check("rst_pc_en", {15'd0, pc_en}, 16'd0);
        check("rst_bubble", {15'd0, bubble}, 16'd0);
        tick();
        check("rst_instr", instr_out, 16'h0800);
        check("rst_pc_inc", pc_inc_out, 16'h0000);
        check("rst_valid", {15'd0, valid_out}, 16'd0);
        check("rst_cnt", stall_cnt, 16'h0000);
        rst = 1'b0;

        drive(0, 0, 0, 16'h4123, 16'h0002);
        check("fetch_pc_en", {15'd0, pc_en}, 16'd1);
        check("fetch_bubble", {15'd0, bubble}, 16'd0);
        tick();
        check("fetch_instr", instr_out, 16'h4123);
        check("fetch_pc_inc", pc_inc_out, 16'h0002);
        check("fetch_valid", {15'd0, valid_out}, 16'd1);

        drive(1, 0, 0, 16'h5555, 16'h0004);
        check("stall1_pc_en", {15'd0, pc_en}, 16'd0);
        check("stall1_bubble", {15'd0, bubble}, 16'd1);
        tick();
        check("stall1_instr", instr_out, 16'h4123);
        drive(1, 0, 0, 16'h6666, 16'h0004);
        check("stall2_pc_en", {15'd0, pc_en}, 16'd0);
        check("stall2_bubble", {15'd0, bubble}, 16'd1);
        tick();
        check("stall2_instr", instr_out, 16'h4123);
        check("stall2_valid", {15'd0, valid_out}, 16'd1);
        drive(0, 0, 0, 16'h1234, 16'h0004);
        tick();
        check("resume_instr", instr_out, 16'h1234);
        check("resume_pc_inc", pc_inc_out, 16'h0004);

        drive(1, 1, 0, 16'h9999, 16'h0006);
        check("fos_pc_en", {15'd0, pc_en}, 16'd1);
        check("fos_bubble", {15'd0, bubble}, 16'd0);
        tick();
        check("fos_instr", instr_out, 16'h0800);
        check("fos_valid", {15'd0, valid_out}, 16'd0);

        drive(0, 1, 1, 16'h8888, 16'h0006);
        check("fkill_pc_en", {15'd0, pc_en}, 16'd1);
        tick();
        drive(0, 0, 0, 16'hC0FF, 16'h0008);
        check("kill_pc_en", {15'd0, pc_en}, 16'd0);
        check("kill_bubble", {15'd0, bubble}, 16'd0);
        tick();
        check("kill_instr", instr_out, 16'h0800);
        check("kill_valid", {15'd0, valid_out}, 16'd0);
        drive(0, 0, 0, 16'h2222, 16'h0008);
        check("postkill_pc_en", {15'd0, pc_en}, 16'd1);
        tick();
        check("postkill_instr", instr_out, 16'h2222);
        check("postkill_valid", {15'd0, valid_out}, 16'd1);

        drive(0, 0, 1, 16'hBAD0, 16'h000A);
        check("imem_pc_en", {15'd0, pc_en}, 16'd0);
        check("imem_bubble", {15'd0, bubble}, 16'd0);
        tick();
        check("imem_instr", instr_out, 16'h0800);
        check("imem_valid", {15'd0, valid_out}, 16'd0);
        drive(0, 0, 0, 16'h3333, 16'h000A);
        check("waitmem_pc_en", {15'd0, pc_en}, 16'd1);
        tick();
        check("waitmem_instr", instr_out, 16'h3333);

        drive(0, 0, 0, 16'h0000, 16'h000C);
        check("halt_pc_en", {15'd0, pc_en}, 16'd1);
        tick();
        check("halt_instr", instr_out, 16'h0000);
        check("halt_valid", {15'd0, valid_out}, 16'd1);
        drive(0, 0, 0, 16'h7777, 16'h000E);
        check("halted1_pc_en", {15'd0, pc_en}, 16'd0);
        tick();
        check("halted1_instr", instr_out, 16'h0800);
        check("halted1_valid", {15'd0, valid_out}, 16'd0);
        check("halted2_pc_en", {15'd0, pc_en}, 16'd0);
        tick();
        check("halted2_instr", instr_out, 16'h0800);
        drive(0, 1, 0, 16'h7777, 16'h000E);
        check("unhalt_pc_en", {15'd0, pc_en}, 16'd1);
        tick();
        drive(0, 0, 0, 16'h4444, 16'h0010);
        check("afterhalt_pc_en", {15'd0, pc_en}, 16'd1);
        tick();
        check("afterhalt_instr", instr_out, 16'h4444);
        check("afterhalt_valid", {15'd0, valid_out}, 16'd1);

        rst = 1'b1;
        drive(0, 0, 0, 16'h0000, 16'h0000);
        tick();
        rst = 1'b0;
        check("cnt_clear", stall_cnt, 16'h0000);
        drive(1, 0, 0, 16'h1111, 16'h0002);
        repeat (3) tick();
        drive(0, 0, 1, 16'h1111, 16'h0002);
        repeat (2) tick();
        drive(0, 1, 1, 16'h1111, 16'h0002);
        tick();
`ifdef IFID_STALL_CNT_EN
        check("cnt_five", stall_cnt, 16'd5);
        drive(1, 0, 0, 16'h1111, 16'h0002);
        repeat (65535) @(posedge clk);
        #1;
        check("cnt_sat", stall_cnt, 16'hFFFF);
        tick();
        check("cnt_sat_hold", stall_cnt, 16'hFFFF);
`else
        check("cnt_off", stall_cnt, 16'h0000);
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
